snake_score_capture: RTL
========================

Name: snake_score_capture

Overview:
Receiver for the multiplexed four-digit seven-segment score interface driven by the scoreboard. It samples the 7-bit segment pattern and the one-hot digit select every clock, and decodes each pattern back to BCD. Once the same four-digit frame has been seen on enough consecutive scans, it converts the BCD digits to binary and publishes the score. It sits in the verification/readback path, for example in self-check logic or in a debug UART feed.

Parameters:
SCORE_WIDTH, 14, width of the reconstructed binary score; results above 2^SCORE_WIDTH-1 saturate to all-ones.
STABLE_FRAMES, 2, number of consecutive identical complete frames (range 1..15) required before a value is published.

Ports:
i_Clk  input  1  system clock, rising edge.
i_Rst_n  input  1  asynchronous, active-low reset.
i_Segments  input  7  segment pattern, active-high, bit0=a .. bit6=g.
i_DigitSelect  input  4  one-hot digit enable; bit3=thousands .. bit0=units.
o_Score  output  SCORE_WIDTH  last published binary score.
o_ScoreValid  output  1  one-cycle pulse when o_Score updates.
o_Digits  output  16  last published BCD digits; [15:12]=thousands .. [3:0]=units.
o_Error  output  1  one-cycle pulse on a protocol or pattern error.

Behaviour:
- Reset (async, i_Rst_n=0): o_Score=0, o_ScoreValid=0, o_Digits=0, o_Error=0.
- Reset also clears: frame mask, stable counter and accumulator; the state returns to COLLECT; the "published-once" flag is cleared.
- Input stage: i_Segments and i_DigitSelect are registered on every edge (edge N). Decode and storage happen on edge N+1.
- Legal patterns (hex, g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any other pattern is illegal.
- Select all-zero: treated as blanking; the sample is ignored, with no error.
- Select not one-hot and not zero: error.
- Illegal pattern with a one-hot select: error.
- Error handling: o_Error pulses on edge N+1, the frame mask is cleared, and the stable counter is reset to 0. The next frame starts clean.
- Valid sample: the decoded digit is written to the slot chosen by the select, and the corresponding mask bit is set. A repeated position within one frame overwrites the slot.
- Frame complete: when the mask reaches 1111 (edge N+1), the frame is compared with the previous complete frame. The mask is cleared in the same cycle.
  - Equal: the stable counter is incremented, saturating at STABLE_FRAMES.
  - Different: the counter is set to 1.
  - The frame becomes the new "previous frame".
- Publish condition: the counter equals STABLE_FRAMES, the state is COLLECT, and either the frame differs from o_Digits or nothing has been published since reset.
- When the publish condition holds: the digits are snapshotted and the state moves to CONVERT.
- FSM COLLECT -> CONVERT (4 cycles) -> PUBLISH -> COLLECT.
  - CONVERT step k: acc = acc*10 + digit[3-k], starting from acc=0 and using at least 14 bits internally.
  - PUBLISH: o_Score = saturated acc, o_Digits = snapshot, o_ScoreValid=1 for exactly one cycle.
- Latency: o_ScoreValid is high in the cycle after edge N+6, where N is the sampling edge of the last digit of the qualifying frame.
- Frames keep being collected and compared during CONVERT and PUBLISH. A frame that qualifies while the FSM is busy is re-evaluated on the first COLLECT cycle: the counter stays saturated, so it publishes if its value differs.
- An error during CONVERT does not abort the conversion in flight; it affects only frame collection.
- Reset mid-CONVERT: outputs return to their reset values immediately, and no valid pulse is produced.

Decomposition:
- Shared package snake_pkg holds:
  - the NUM_DIGITS=4 constant;
  - the ten seven-segment pattern constants (shared with the scoreboard encoder);
  - the FSM state encoding (COLLECT, CONVERT, PUBLISH).
- One sub-module, snake_segment_decoder: combinational, 7-bit pattern -> 4-bit BCD plus a legal flag. It is reusable for any other display readback.

Test Plan:
- Reset: assert i_Rst_n=0 mid-stream -> all outputs 0 immediately (asynchronous); no o_ScoreValid until STABLE_FRAMES complete frames have been seen after release.
- Scan 1234 (selects 0001,0010,0100,1000 with patterns 4=66, 3=4F, 2=5B, 1=06) for 2 frames -> o_Score=1234 and o_Digits=16'h1234; valid pulse is 1 cycle wide, at N+6 after the last digit of frame 2.
- Illegal pattern 7'h00 in the middle of frame 2 -> o_Error pulses once; 1234 is published only after two further clean frames.
- i_DigitSelect=0011 -> o_Error pulse with no state corruption. i_DigitSelect=0000 for 10 cycles inside a frame -> ignored; the frame still completes.
- Continuous scan of 1234 for 20 frames -> exactly one valid pulse. Switch to 9999 -> one pulse, o_Score=9999. With SCORE_WIDTH=13 -> o_Score=8191 (saturated).
- Reset asserted during CONVERT -> no pulse and o_Score=0. After release, a clean 0042 scan publishes o_Score=42.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the seven-segment score readback path.
//   NUM_DIGITS  : digits per multiplexed frame
//   ACC_WIDTH   : internal width of the BCD-to-binary accumulator (holds 9999)
//   SEG_0..9    : active-high segment patterns, bit0=a .. bit6=g; the
//                 scoreboard encoder uses the same constants
//   state_t     : capture FSM state encoding
package snake_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int ACC_WIDTH  = 14;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CONVERT = 2'd1,
    PUBLISH = 2'd2
  } state_t;

endpackage

// File: rtl/snake_segment_decoder.sv
// Combinational seven-segment pattern to BCD decoder.
//   pattern : 7-bit active-high segment pattern, bit0=a .. bit6=g
//   digit   : decoded BCD value (0 when the pattern is illegal)
//   legal   : high when pattern is one of the ten digit patterns
module snake_segment_decoder
  import snake_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       legal
);

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (pattern)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/snake_score_capture.sv
// Receiver for the multiplexed four-digit seven-segment score display.
// Reconstructs BCD frames, waits for STABLE_FRAMES identical complete frames,
// then converts to binary and publishes the score.
//   i_Clk          : system clock, rising edge
//   i_Rst_n        : asynchronous active-low reset
//   i_Segments     : segment pattern, bit0=a .. bit6=g
//   i_DigitSelect  : one-hot digit enable, bit3=thousands .. bit0=units
//   o_Score        : last published binary score (saturating)
//   o_ScoreValid   : one-cycle pulse when o_Score updates
//   o_Digits       : last published BCD digits, [15:12]=thousands
//   o_Error        : one-cycle pulse on a bad select or illegal pattern
//
// state   | meaning
// COLLECT | idle; publishes when a stable frame differs from o_Digits
// CONVERT | four BCD-to-binary steps, thousands digit first
// PUBLISH | o_Score/o_Digits just updated, o_ScoreValid high
module snake_score_capture
  import snake_pkg::*;
#(
  parameter int SCORE_WIDTH   = 14,
  parameter int STABLE_FRAMES = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic [6:0]             i_Segments,
  input  logic [3:0]             i_DigitSelect,
  output logic [SCORE_WIDTH-1:0] o_Score,
  output logic                   o_ScoreValid,
  output logic [15:0]            o_Digits,
  output logic                   o_Error
);

  localparam logic [3:0]  STABLE_CNT = 4'(STABLE_FRAMES);
  localparam logic [31:0] SCORE_MAX  = (SCORE_WIDTH >= 32) ? 32'hFFFF_FFFF
                                       : ((32'd1 << SCORE_WIDTH) - 32'd1);

  logic [6:0]           seg_q;
  logic [3:0]           sel_q;
  logic [3:0]           dec_digit;
  logic                 dec_legal;
  logic [15:0]          frame_buf, frame_next, prev_frame, snapshot;
  logic [3:0]           mask, mask_next;
  logic [3:0]           stable_cnt;
  logic                 published;
  logic [ACC_WIDTH-1:0] acc, acc_next;
  logic [1:0]           step;
  logic [3:0]           cur_digit;
  logic [31:0]          final_ext;
  logic                 sample_ok, sample_err, frame_done, publish_go;
  state_t               state, state_next;

  snake_segment_decoder u_decoder (
    .pattern (seg_q),
    .digit   (dec_digit),
    .legal   (dec_legal)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      seg_q <= '0;
      sel_q <= '0;
    end else begin
      seg_q <= i_Segments;
      sel_q <= i_DigitSelect;
    end
  end

  // An all-zero select is display blanking and is neither stored nor an error.
  always_comb begin
    sample_ok  = $onehot(sel_q) && dec_legal;
    sample_err = (sel_q != 4'd0) && !sample_ok;
    mask_next  = mask | sel_q;
    frame_next = frame_buf;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_q[i]) frame_next[i*4 +: 4] = dec_digit;
    end
    frame_done = sample_ok && (mask_next == 4'hF);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      frame_buf  <= '0;
      mask       <= '0;
      prev_frame <= '0;
      stable_cnt <= '0;
      o_Error    <= 1'b0;
    end else begin
      o_Error <= sample_err;
      if (sample_err) begin
        mask       <= '0;
        stable_cnt <= '0;
      end else if (sample_ok) begin
        frame_buf <= frame_next;
        if (frame_done) begin
          mask       <= '0;
          prev_frame <= frame_next;
          if (frame_next == prev_frame)
            stable_cnt <= (stable_cnt >= STABLE_CNT) ? stable_cnt : stable_cnt + 4'd1;
          else
            stable_cnt <= 4'd1;
        end else begin
          mask <= mask_next;
        end
      end
    end
  end

  // A frame that saturated the counter while busy is picked up here on the
  // first COLLECT cycle, because the counter stays saturated.
  assign publish_go = (state == COLLECT) && (stable_cnt == STABLE_CNT) &&
                      (!published || (prev_frame != o_Digits));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= COLLECT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (publish_go) state_next = CONVERT;
      CONVERT: if (step == 2'd3) state_next = PUBLISH;
      PUBLISH: state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    o_ScoreValid = (state == PUBLISH);
  end

  always_comb begin
    cur_digit = snapshot[{2'd3 - step, 2'b00} +: 4];
    acc_next  = ACC_WIDTH'(acc * ACC_WIDTH'(10)) + ACC_WIDTH'(cur_digit);
    final_ext = 32'(acc_next);
  end

  // Outputs load on the last conversion edge so they are stable while
  // o_ScoreValid is high in PUBLISH.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      snapshot  <= '0;
      acc       <= '0;
      step      <= '0;
      published <= 1'b0;
      o_Score   <= '0;
      o_Digits  <= '0;
    end else if (publish_go) begin
      snapshot <= prev_frame;
      acc      <= '0;
      step     <= '0;
    end else if (state == CONVERT) begin
      acc  <= acc_next;
      step <= step + 2'd1;
      if (step == 2'd3) begin
        o_Score   <= (final_ext > SCORE_MAX) ? '1 : final_ext[SCORE_WIDTH-1:0];
        o_Digits  <= snapshot;
        published <= 1'b1;
      end
    end
  end

endmodule
